// File: rtl/cpu_pkg.sv
// Shared types for the 8-bit core: opcode classes, execute-stage FSM states
// and flag bit positions.
package cpu_pkg;

  localparam int DATA_W = 8;
  localparam int REG_W  = 2;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_AND = 4'h3,
    OP_OR  = 4'h4,
    OP_XOR = 4'h5,
    OP_SHL = 4'h6,
    OP_SHR = 4'h7,
    OP_MOV = 4'h8,
    OP_LD  = 4'h9,
    OP_ST  = 4'hA,
    OP_JMP = 4'hB,
    OP_BZ  = 4'hC,
    OP_BC  = 4'hD,
    OP_CMP = 4'hE,
    OP_HLT = 4'hF
  } op_class_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IMM  = 2'd1,
    LOAD = 2'd2,
    HALT = 2'd3
  } exec_state_t;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;

  // Arithmetic/logic classes and CMP are the only ones that touch {C, Z}.
  function automatic logic updates_flags(op_class_t cls);
    case (cls)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_SHL, OP_SHR, OP_CMP: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU for the execute stage: 8-bit result plus carry/borrow
// and zero indications.
module alu
  import cpu_pkg::*;
(
  input  logic [3:0] cls,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] result,
  output logic       c,
  output logic       z
);

  logic [8:0] wide;

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    wide   = 9'd0;
    result = 8'h00;
    c      = 1'b0;
    case (op_class_t'(cls))
      OP_ADD: begin
        wide   = {1'b0, a} + {1'b0, b};
        result = wide[7:0];
        c      = wide[8];
      end
      // Bit 8 of the 9-bit difference is the unsigned borrow.
      OP_SUB, OP_CMP: begin
        wide   = {1'b0, a} - {1'b0, b};
        result = wide[7:0];
        c      = wide[8];
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SHL: begin
        result = {a[6:0], 1'b0};
        c      = a[7];
      end
      OP_SHR: begin
        result = {1'b0, a[7:1]};
        c      = a[0];
      end
      OP_MOV:  result = b;
      default: result = 8'h00;
    endcase
  end

  assign z = (result == 8'h00);

endmodule

// File: rtl/execute.sv
// Execute stage: takes decoded instructions, collects the optional immediate,
// runs the ALU, performs loads/stores and issues branch redirects.
module execute
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       sync_rst,
  input  logic       valid_in,
  input  logic [7:0] opc_in,
  input  logic [1:0] dst_in,
  input  logic [7:0] data_A,
  input  logic [7:0] data_B,
  input  logic       has_imm,
  input  logic [7:0] imm_word,
  input  logic       imm_valid,
  output logic       stall_en,
  output logic       reg_write_en,
  output logic [1:0] reg_write_addr,
  output logic [7:0] reg_write_data,
  output logic       mem_read_en,
  output logic       mem_write_en,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_write_data,
  input  logic [7:0] mem_read_data,
  output logic [7:0] branch_wr,
  output logic       branch_wr_en,
  output logic [1:0] flags,
  output logic       halted
);

  exec_state_t state_q, state_d;
  op_class_t   cls_q;
  logic [1:0]  dst_q;
  logic [7:0]  a_q;
  logic        shadow_q;
  logic [1:0]  flags_q;
  logic [7:0]  st_addr_q;

  op_class_t   in_cls;
  logic        accept;
  logic        fire;
  op_class_t   ex_cls;
  logic [7:0]  ex_a;
  logic [7:0]  ex_b;
  logic [1:0]  ex_dst;
  logic [7:0]  alu_result;
  logic        alu_c;
  logic        alu_z;
  logic        writes_reg;
  logic        taken;
  logic        unused_opc_low;

  assign in_cls         = op_class_t'(opc_in[7:4]);
  assign unused_opc_low = ^opc_in[3:0];
  assign accept         = valid_in && (state_q == IDLE) && !shadow_q;

  // Execution happens either straight from decode or when the trailing
  // immediate arrives for the instruction captured at accept.
  always_comb begin
    fire   = 1'b0;
    ex_cls = cls_q;
    ex_a   = a_q;
    ex_b   = imm_word;
    ex_dst = dst_q;
    if (accept && !has_imm) begin
      fire   = 1'b1;
      ex_cls = in_cls;
      ex_a   = data_A;
      ex_b   = data_B;
      ex_dst = dst_in;
    end else if (state_q == IMM && imm_valid) begin
      fire = 1'b1;
    end
  end

  alu u_alu (
    .cls    (ex_cls),
    .a      (ex_a),
    .b      (ex_b),
    .result (alu_result),
    .c      (alu_c),
    .z      (alu_z)
  );

  assign writes_reg = fire && (ex_cls inside {OP_ADD, OP_SUB, OP_AND, OP_OR,
                                              OP_XOR, OP_SHL, OP_SHR, OP_MOV});
  assign taken = fire && ((ex_cls == OP_JMP) ||
                          (ex_cls == OP_BZ && flags_q[FLAG_Z]) ||
                          (ex_cls == OP_BC && flags_q[FLAG_C]));

  // The load address goes out in the execute cycle; data returns next cycle.
  assign mem_read_en = fire && (ex_cls == OP_LD);
  assign mem_addr    = mem_read_en ? ex_b : st_addr_q;
  assign stall_en    = (state_q != IDLE) | (valid_in & (has_imm | (in_cls == OP_LD)));
  assign halted      = (state_q == HALT);
  assign flags       = flags_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (has_imm)               state_d = IMM;
          else if (in_cls == OP_HLT) state_d = HALT;
          else if (in_cls == OP_LD)  state_d = LOAD;
        end
      end
      IMM: begin
        if (imm_valid) begin
          if (cls_q == OP_HLT)     state_d = HALT;
          else if (cls_q == OP_LD) state_d = LOAD;
          else                     state_d = IDLE;
        end
      end
      LOAD:    state_d = IDLE;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!sync_rst) begin
      state_q        <= IDLE;
      cls_q          <= OP_NOP;
      dst_q          <= 2'd0;
      a_q            <= 8'h00;
      shadow_q       <= 1'b0;
      flags_q        <= 2'b00;
      st_addr_q      <= 8'h00;
      mem_write_data <= 8'h00;
      mem_write_en   <= 1'b0;
      reg_write_en   <= 1'b0;
      reg_write_addr <= 2'd0;
      reg_write_data <= 8'h00;
      branch_wr      <= 8'h00;
      branch_wr_en   <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= branch_wr_en;
      reg_write_en <= 1'b0;
      mem_write_en <= 1'b0;
      branch_wr_en <= 1'b0;
      if (accept) begin
        cls_q <= in_cls;
        dst_q <= dst_in;
        a_q   <= data_A;
      end
      if (writes_reg) begin
        reg_write_en   <= 1'b1;
        reg_write_addr <= ex_dst;
        reg_write_data <= alu_result;
      end
      if (state_q == LOAD) begin
        reg_write_en   <= 1'b1;
        reg_write_addr <= dst_q;
        reg_write_data <= mem_read_data;
      end
      if (fire && ex_cls == OP_ST) begin
        mem_write_en   <= 1'b1;
        st_addr_q      <= ex_b;
        mem_write_data <= ex_a;
      end
      if (taken) begin
        branch_wr_en <= 1'b1;
        branch_wr    <= ex_b;
      end
      if (fire && updates_flags(ex_cls)) begin
        flags_q <= {alu_c, alu_z};
      end
    end
  end

endmodule

// File: tb/tb_execute.sv
// Self-checking bench for the execute stage: table-driven ALU vectors plus
// directed multi-cycle sequences, with write/branch events scoreboarded.
module tb_execute;

  logic       clk = 1'b0;
  logic       sync_rst;
  logic       valid_in;
  logic [7:0] opc_in;
  logic [1:0] dst_in;
  logic [7:0] data_A;
  logic [7:0] data_B;
  logic       has_imm;
  logic [7:0] imm_word;
  logic       imm_valid;
  logic       stall_en;
  logic       reg_write_en;
  logic [1:0] reg_write_addr;
  logic [7:0] reg_write_data;
  logic       mem_read_en;
  logic       mem_write_en;
  logic [7:0] mem_addr;
  logic [7:0] mem_write_data;
  logic [7:0] mem_read_data;
  logic [7:0] branch_wr;
  logic       branch_wr_en;
  logic [1:0] flags;
  logic       halted;

  execute dut (
    .clk            (clk),
    .sync_rst       (sync_rst),
    .valid_in       (valid_in),
    .opc_in         (opc_in),
    .dst_in         (dst_in),
    .data_A         (data_A),
    .data_B         (data_B),
    .has_imm        (has_imm),
    .imm_word       (imm_word),
    .imm_valid      (imm_valid),
    .stall_en       (stall_en),
    .reg_write_en   (reg_write_en),
    .reg_write_addr (reg_write_addr),
    .reg_write_data (reg_write_data),
    .mem_read_en    (mem_read_en),
    .mem_write_en   (mem_write_en),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .branch_wr      (branch_wr),
    .branch_wr_en   (branch_wr_en),
    .flags          (flags),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  localparam int EV_REG = 0;
  localparam int EV_MEM = 1;
  localparam int EV_BR  = 2;

  typedef struct {
    int         kind;
    logic [7:0] addr;
    logic [7:0] data;
    int         at;
  } ev_t;

  typedef struct {
    logic [3:0] cls;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] dst;
    logic [7:0] res;
    logic [1:0] fl;
  } vec_t;

  ev_t  exp_q[$];
  vec_t vecs[13];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [7:0] addr, input logic [7:0] data,
                           input int at);
    ev_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind, input logic [7:0] addr, input logic [7:0] data);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_event: got kind %0d addr 0x%0h data 0x%0h at cycle %0d, expected none",
               kind, addr, data, cyc);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      check("event_addr", {24'd0, addr}, {24'd0, e.addr});
      check("event_data", {24'd0, data}, {24'd0, e.data});
      check("event_cycle", cyc, e.at);
    end
  endtask

  always @(negedge clk) begin
    if (reg_write_en === 1'b1) observe(EV_REG, {6'd0, reg_write_addr}, reg_write_data);
    if (mem_write_en === 1'b1) observe(EV_MEM, mem_addr, mem_write_data);
    if (branch_wr_en === 1'b1) observe(EV_BR, 8'h00, branch_wr);
  end

  task automatic drive(input logic v, input logic [7:0] opc, input logic [1:0] dst,
                       input logic [7:0] a, input logic [7:0] b, input logic hi,
                       input logic [7:0] iw, input logic iv);
    valid_in  = v;
    opc_in    = opc;
    dst_in    = dst;
    data_A    = a;
    data_B    = b;
    has_imm   = hi;
    imm_word  = iw;
    imm_valid = iv;
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 2'd0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctl"}, {22'd0, reg_write_en, mem_write_en, branch_wr_en, mem_read_en,
                           halted, stall_en, flags, reg_write_addr}, 32'd0);
    check({name, "_data"}, {reg_write_data, mem_addr, mem_write_data, branch_wr}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected under 10000", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{4'h1, 8'hF0, 8'h20, 2'd2, 8'h10, 2'b10};
    vecs[1]  = '{4'h2, 8'h05, 8'h07, 2'd1, 8'hFE, 2'b10};
    vecs[2]  = '{4'h2, 8'h07, 8'h07, 2'd3, 8'h00, 2'b01};
    vecs[3]  = '{4'h3, 8'hF0, 8'h0F, 2'd0, 8'h00, 2'b01};
    vecs[4]  = '{4'h4, 8'hA0, 8'h05, 2'd1, 8'hA5, 2'b00};
    vecs[5]  = '{4'h5, 8'hFF, 8'hFF, 2'd2, 8'h00, 2'b01};
    vecs[6]  = '{4'h6, 8'h81, 8'h55, 2'd3, 8'h02, 2'b10};
    vecs[7]  = '{4'h7, 8'h01, 8'h55, 2'd0, 8'h00, 2'b11};
    vecs[8]  = '{4'h7, 8'h80, 8'h55, 2'd1, 8'h40, 2'b00};
    vecs[9]  = '{4'h1, 8'h80, 8'h80, 2'd2, 8'h00, 2'b11};
    vecs[10] = '{4'h8, 8'h12, 8'h34, 2'd3, 8'h34, 2'b11};
    vecs[11] = '{4'h1, 8'hFF, 8'h00, 2'd0, 8'hFF, 2'b00};
    vecs[12] = '{4'h2, 8'h00, 8'h01, 2'd1, 8'hFF, 2'b10};

    sync_rst      = 1'b0;
    mem_read_data = 8'h00;
    idle();
    step();
    step();
    check_all_zero("reset");
    sync_rst = 1'b1;

    // Back-to-back single-cycle ALU ops, one per cycle.
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, {vecs[i].cls, 4'(i)}, vecs[i].dst, vecs[i].a, vecs[i].b, 1'b0, 8'h00, 1'b0);
      expect_ev(EV_REG, {6'd0, vecs[i].dst}, vecs[i].res, cyc + 1);
      #1 check($sformatf("stall_vec%0d", i), {31'd0, stall_en}, 32'd0);
      step();
      check($sformatf("flags_vec%0d", i), {30'd0, flags}, {30'd0, vecs[i].fl});
    end
    idle();
    step();

    // CMP 5 vs imm 5, then taken BZ with imm; the op after the pulse is dropped.
    drive(1'b1, 8'hE0, 2'd0, 8'h05, 8'hAA, 1'b1, 8'h00, 1'b0);
    #1 check("stall_cmp_imm", {31'd0, stall_en}, 32'd1);
    step();
    drive(1'b0, 8'hE0, 2'd0, 8'h05, 8'hAA, 1'b0, 8'h05, 1'b1);
    step();
    check("flags_cmp_equal", {30'd0, flags}, 32'd1);
    drive(1'b1, 8'hC0, 2'd0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0);
    step();
    drive(1'b0, 8'hC0, 2'd0, 8'h00, 8'h00, 1'b0, 8'h40, 1'b1);
    expect_ev(EV_BR, 8'h00, 8'h40, cyc + 1);
    step();
    idle();
    step();
    drive(1'b1, 8'h10, 2'd3, 8'h01, 8'h01, 1'b0, 8'h00, 1'b0);
    step();
    check("flags_after_shadow", {30'd0, flags}, 32'd1);
    drive(1'b1, 8'h10, 2'd3, 8'h01, 8'h01, 1'b0, 8'h00, 1'b0);
    expect_ev(EV_REG, 8'h03, 8'h02, cyc + 1);
    step();
    check("flags_after_add", {30'd0, flags}, 32'd0);

    // Untaken BZ: no pulse and no shadow, next op executes immediately.
    drive(1'b1, 8'hC0, 2'd0, 8'h00, 8'h50, 1'b0, 8'h00, 1'b0);
    step();
    drive(1'b1, 8'h10, 2'd1, 8'h07, 8'h08, 1'b0, 8'h00, 1'b0);
    expect_ev(EV_REG, 8'h01, 8'h0F, cyc + 1);
    step();
    idle();
    step();

    // LD from register operand: read at E, data at E+1, write at E+2.
    drive(1'b1, 8'h90, 2'd1, 8'h00, 8'h80, 1'b0, 8'h00, 1'b0);
    mem_read_data = 8'hEE;
    expect_ev(EV_REG, 8'h01, 8'h5A, cyc + 2);
    #1;
    check("ld_read_en", {31'd0, mem_read_en}, 32'd1);
    check("ld_addr", {24'd0, mem_addr}, 32'h80);
    check("ld_stall_e", {31'd0, stall_en}, 32'd1);
    step();
    idle();
    mem_read_data = 8'h5A;
    #1;
    check("ld_stall_e1", {31'd0, stall_en}, 32'd1);
    check("ld_read_en_e1", {31'd0, mem_read_en}, 32'd0);
    step();
    mem_read_data = 8'hEE;
    #1 check("ld_stall_done", {31'd0, stall_en}, 32'd0);

    // LD with immediate address.
    drive(1'b1, 8'h90, 2'd0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0);
    step();
    drive(1'b0, 8'h90, 2'd0, 8'h00, 8'h00, 1'b0, 8'h81, 1'b1);
    expect_ev(EV_REG, 8'h00, 8'h77, cyc + 2);
    #1 check("ldi_addr", {24'd0, mem_addr}, 32'h81);
    step();
    idle();
    mem_read_data = 8'h77;
    step();
    mem_read_data = 8'hEE;
    step();

    // ST with immediate arriving three cycles late; A captured at accept.
    drive(1'b1, 8'hA0, 2'd0, 8'h33, 8'hCC, 1'b1, 8'h00, 1'b0);
    step();
    for (int w = 0; w < 3; w++) begin
      drive(1'b1, 8'hA0, 2'd0, 8'h99, 8'hCC, 1'b1, 8'h55, 1'b0);
      #1 check($sformatf("st_stall_wait%0d", w), {31'd0, stall_en}, 32'd1);
      step();
    end
    drive(1'b0, 8'hA0, 2'd0, 8'h99, 8'hCC, 1'b0, 8'h10, 1'b1);
    expect_ev(EV_MEM, 8'h10, 8'h33, cyc + 1);
    step();
    idle();
    #1 check("st_stall_done", {31'd0, stall_en}, 32'd0);

    // Set non-zero flags and write data, then HLT and try more ADDs.
    drive(1'b1, 8'h10, 2'd3, 8'h90, 8'h80, 1'b0, 8'h00, 1'b0);
    expect_ev(EV_REG, 8'h03, 8'h10, cyc + 1);
    step();
    check("flags_add_carry", {30'd0, flags}, 32'd2);
    drive(1'b1, 8'hF0, 2'd0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    step();
    check("halted_set", {31'd0, halted}, 32'd1);
    for (int h = 0; h < 3; h++) begin
      drive(1'b1, 8'h10, 2'd2, 8'h01, 8'h01, 1'b0, 8'h00, 1'b0);
      #1 check($sformatf("halt_stall%0d", h), {31'd0, stall_en}, 32'd1);
      step();
    end
    check("halted_hold", {31'd0, halted}, 32'd1);
    idle();
    sync_rst = 1'b0;
    step();
    check_all_zero("halt_reset");
    sync_rst = 1'b1;

    // Reset while waiting for a JMP immediate discards the jump.
    drive(1'b1, 8'hB0, 2'd0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0);
    step();
    drive(1'b0, 8'hB0, 2'd0, 8'h00, 8'h00, 1'b0, 8'h66, 1'b1);
    sync_rst = 1'b0;
    step();
    sync_rst = 1'b1;
    idle();
    #1;
    check("imm_reset_no_branch", {31'd0, branch_wr_en}, 32'd0);
    check("imm_reset_idle", {31'd0, stall_en}, 32'd0);
    drive(1'b1, 8'h10, 2'd1, 8'h03, 8'h04, 1'b0, 8'h00, 1'b0);
    expect_ev(EV_REG, 8'h01, 8'h07, cyc + 1);
    step();
    check("flags_after_reset_add", {30'd0, flags}, 32'd0);
    idle();
    step();
    step();
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/execute.md
# execute

Execute stage of the 8-bit core, directly downstream of `decode`. It accepts a decoded instruction (opcode, two register operands, destination, immediate flag), fetches the trailing immediate word when present, runs the ALU, and performs loads and stores against `memory`. It produces the register-file write port, the `branch_wr`/`branch_wr_en` redirect consumed by `fetch`, and the `stall_en` back-pressure consumed by `decode`.

## Interface
- No parameters. Data width is fixed at 8; register address width is fixed at 2.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `sync_rst` in 1: synchronous, active-low reset; sampled on the rising edge of `clk`.
- `valid_in` in 1: decode presents an instruction this cycle.
- `opc_in` in 8: decoded opcode; class = `opc_in[7:4]`, with `[3:0]` ignored.
- `dst_in` in 2: destination register.
- `data_A`, `data_B` in 8: register operands.
- `has_imm` in 1: the instruction is followed by one immediate word.
- `imm_word` in 8, `imm_valid` in 1: immediate word from fetch.
- `stall_en` out 1: decode must hold its outputs.
- `reg_write_en` out 1, `reg_write_addr` out 2, `reg_write_data` out 8: register-file write.
- `mem_read_en` out 1, `mem_write_en` out 1, `mem_addr` out 8, `mem_write_data` out 8, `mem_read_data` in 8: data memory. Read latency is 1 cycle.
- `branch_wr` out 8, `branch_wr_en` out 1: PC redirect.
- `flags` out 2: {C, Z}.
- `halted` out 1.

## Operation
- Operand B' = `imm_word` when `has_imm`, else `data_B`.
- Opcode classes:
  - 0 NOP
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR: dst ← A op B'
  - 6 SHL, 7 SHR: dst ← A shifted by 1
  - 8 MOV: dst ← B'
  - 9 LD: dst ← mem[B']
  - A ST: mem[B'] ← A
  - B JMP: PC ← B'
  - C BZ: branch if Z; D BC: branch if C
  - E CMP: flags only, from A−B'
  - F HLT
- Arithmetic is modulo 256.
  - ADD: C = bit 8 of the 9-bit sum.
  - SUB/CMP: C = borrow (A < B', unsigned).
  - SHL: C = A[7]. SHR: C = A[0].
  - AND/OR/XOR: C = 0.
  - Z = (8-bit result == 0).
  - Classes 1–7 and E update both flags. All other classes leave the flags unchanged.
- FSM states:
  - IDLE → IMM on accept with `has_imm`.
  - IDLE → LOAD on accept of LD without imm.
  - IMM → LOAD when `imm_valid` and the class is LD.
  - IMM → IDLE when `imm_valid` and the class is any other.
  - LOAD → IDLE after one cycle.
  - Any state → HALT on HLT execute. HALT is left only by reset.
- Accept: `valid_in` && state == IDLE && !shadow. The opcode, dst and A are captured into internal registers at accept.
- `stall_en` (combinational) = (state != IDLE) | (`valid_in` & (`has_imm` | class == LD)).
- Shadow: the cycle after `branch_wr_en` = 1, `valid_in` is ignored. That instruction was fetched on the wrong path and is dropped.
- Reset (`sync_rst` = 0): every output register goes to 0, flags = 0, state = IDLE, shadow = 0. A reset mid-IMM or mid-LOAD discards the in-flight instruction with no register write.

## Timing
- Single-cycle op (no imm, not LD) accepted at cycle N: `reg_write_*` / `mem_write_en` / `branch_wr_en` are registered and pulse for exactly one cycle at N+1. Flags update at N+1.
- With imm: execution occurs in the cycle `imm_valid` = 1 while in IMM; results appear on the following cycle. `imm_valid` may arrive after any number of cycles.
- LD at execute cycle E:
  - `mem_read_en` = 1 and `mem_addr` = B' at E.
  - `mem_read_data` is sampled at E+1.
  - `reg_write_en` pulses at E+2.
- ST: `mem_write_en`, `mem_addr` and `mem_write_data` pulse together for one cycle.
- An untaken BZ/BC produces no pulse and no shadow.
- Back-to-back single-cycle ops sustain 1 instruction/cycle.
- A flag consumer sees the flags of the immediately preceding op. There is no bypass hazard because the flags are written at N+1, before the next op can execute.

## Structure
- `cpu_pkg`: opcode-class enum (`OP_NOP`…`OP_HLT`), `exec_state_t` {IDLE, IMM, LOAD, HALT}, flag bit indices `FLAG_Z` = 0, `FLAG_C` = 1.
- Sub-module `alu`: combinational; inputs class, A, B'; outputs 8-bit result, C, Z. Instantiated once in `execute`.

## Test plan
- ADD with A = 0xF0, B = 0x20, dst = 2 → at N+1, write r2 = 0x10; C = 1, Z = 0.
- CMP with A = 5, then `has_imm` with imm 5; next instruction BZ with imm 0x40 → `branch_wr` = 0x40 pulses once; a `valid_in` ADD the following cycle is dropped (no write).
- LD with B = 0x80, `mem_read_data` = 0x5A → `mem_read_en` at E, r1 = 0x5A written at E+2; `stall_en` high throughout.
- ST with A = 0x33, imm 0x10 where `imm_valid` is delayed 3 cycles → `stall_en` stays high 3 cycles, then one write pulse with addr 0x10, data 0x33.
- HLT followed by ADDs → `halted` = 1, `stall_en` stuck at 1, no writes; `sync_rst` = 0 for one cycle → all outputs 0, IDLE.
- Reset asserted in the IMM state → no write, no branch; the next instruction executes normally.
